// File: rtl/rf_ctrl_pkg.sv
// Shared encodings and instruction field positions for the register-file port controller.
package rf_ctrl_pkg;
  localparam int RS_LSB   = 21;
  localparam int RT_LSB   = 16;
  localparam int RD_LSB   = 11;
  localparam int ZERO_REG = 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_OPS, ST_WAIT_RES, ST_WSETUP, ST_WSTROBE, ST_WHOLD, ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    WS_IDLE, WS_SETUP, WS_STROBE, WS_HOLD
  } ws_state_t;
endpackage

// File: rtl/rf_write_seq.sv
// Setup/strobe/hold write sequencer: address and data are frozen one cycle before
// the single-cycle registered write enable and stay frozen for HOLD_CYCLES after it.
module rf_write_seq
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_rf_rd,
  output logic [DATA_W-1:0] o_rf_wd,
  output logic              o_rf_we,
  output logic              o_busy,
  output logic              o_fin
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  ws_state_t         r_state;
  ws_state_t         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_fin;

  always_comb begin
    w_next = r_state;
    w_fin  = 1'b0;
    case (r_state)
      WS_IDLE:   if (i_start) w_next = WS_SETUP;
      WS_SETUP:  w_next = WS_STROBE;
      WS_STROBE: w_next = WS_HOLD;
      WS_HOLD: begin
        if (r_cnt == '0) begin
          w_fin  = 1'b1;
          w_next = WS_IDLE;
        end
      end
      default:   w_next = WS_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= WS_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // Enable is a flop so it can only rise/fall on edges where addr/data are already frozen.
      r_we    <= (w_next == WS_STROBE);
      if (r_state == WS_IDLE && i_start) begin
        r_addr <= i_addr;
        r_data <= i_data;
      end
      if (r_state == WS_STROBE)
        r_cnt <= CNT_W'(HOLD_CYCLES - 1);
      else if (r_state == WS_HOLD && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_rf_rd = r_addr;
  assign o_rf_wd = r_data;
  assign o_rf_we = r_we;
  assign o_busy  = (r_state != WS_IDLE);
  assign o_fin   = w_fin;
endmodule

// File: rtl/regfile_port_ctrl.sv
// Initiator side of the 32x8 register-file port: operand read, operand latch,
// result wait and a protected setup/strobe/hold writeback.
module regfile_port_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_instr_valid,
  input  logic [31:0]       i_instr,
  input  logic              i_instr_dst_rd,
  input  logic              i_instr_wb,
  output logic              o_instr_ready,
  output logic [DATA_W-1:0] o_op_a,
  output logic [DATA_W-1:0] o_op_b,
  output logic              o_operands_valid,
  input  logic              i_result_valid,
  input  logic [DATA_W-1:0] i_result,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_rf_rs,
  output logic [ADDR_W-1:0] o_rf_rt,
  output logic [ADDR_W-1:0] o_rf_rd,
  output logic [DATA_W-1:0] o_rf_wd,
  output logic              o_rf_we,
  input  logic [DATA_W-1:0] i_rf_rd1,
  input  logic [DATA_W-1:0] i_rf_rd2
);
  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_rs;
  logic [ADDR_W-1:0] r_rt;
  logic [ADDR_W-1:0] r_dest;
  logic              r_wb;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic              r_opv;
  logic              w_ws_start;
  logic              w_ws_busy;
  logic              w_ws_fin;
  logic              w_dest_zero;
  logic              w_unused_instr;

  assign w_unused_instr = ^{i_instr[31:26], i_instr[10:0]};
  assign w_dest_zero    = (r_dest == ADDR_W'(ZERO_REG));
  // $0 is hardwired, so a writeback aimed at it is dropped rather than strobed.
  assign w_ws_start     = (r_state == ST_WAIT_RES) && r_wb && i_result_valid &&
                          !w_dest_zero && !w_ws_busy;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (i_instr_valid) w_next = ST_READ;
      ST_READ:     w_next = ST_OPS;
      ST_OPS:      w_next = ST_WAIT_RES;
      ST_WAIT_RES: begin
        if (!r_wb)
          w_next = ST_DONE;
        else if (i_result_valid)
          w_next = w_dest_zero ? ST_DONE : ST_WSETUP;
      end
      ST_WSETUP:   w_next = ST_WSTROBE;
      ST_WSTROBE:  w_next = ST_WHOLD;
      ST_WHOLD:    if (w_ws_fin) w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_rs    <= '0;
      r_rt    <= '0;
      r_dest  <= '0;
      r_wb    <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_opv   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_opv   <= (r_state == ST_OPS);
      if (r_state == ST_IDLE && i_instr_valid) begin
        r_rs   <= i_instr[RS_LSB +: ADDR_W];
        r_rt   <= i_instr[RT_LSB +: ADDR_W];
        r_dest <= i_instr_dst_rd ? i_instr[RD_LSB +: ADDR_W] : i_instr[RT_LSB +: ADDR_W];
        r_wb   <= i_instr_wb;
      end
      if (r_state == ST_OPS) begin
        r_op_a <= i_rf_rd1;
        r_op_b <= i_rf_rd2;
      end
    end
  end

  rf_write_seq #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_wseq (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (w_ws_start),
    .i_addr  (r_dest),
    .i_data  (i_result),
    .o_rf_rd (o_rf_rd),
    .o_rf_wd (o_rf_wd),
    .o_rf_we (o_rf_we),
    .o_busy  (w_ws_busy),
    .o_fin   (w_ws_fin)
  );

  assign o_instr_ready    = (r_state == ST_IDLE);
  assign o_done           = (r_state == ST_DONE);
  assign o_op_a           = r_op_a;
  assign o_op_b           = r_op_b;
  assign o_operands_valid = r_opv;
  assign o_rf_rs          = r_rs;
  assign o_rf_rt          = r_rt;
endmodule
